// File: rtl/uart_pkg.sv
// Shared UART constants and the receive FSM state type, used by both the RX and TX paths.
package uart_pkg;

  localparam int CLK_HZ       = 5_760_000;
  localparam int BAUD         = 115_200;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2 - 1;
  localparam int DATA_BITS    = 8;
  localparam int STOP_BITS    = 1;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous idle-high input; both flops reset to 1
// so a line that is idle at reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_b,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized RX line, a holding register
// with a valid/ack handshake, and single-cycle framing and overrun pulses.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       framing_err,
  output logic       overrun_err,
  output rx_state_e  state_dbg
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             sample_bit;
  logic             load;
  logic             frame_bad;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_b (reset_b),
    .d       (rx_in),
    .q       (rx_s)
  );

  always_comb begin
    state_d    = state_q;
    sample_bit = 1'b0;
    load       = 1'b0;
    frame_bad  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt_q == CNT_HALF) state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          sample_bit = 1'b1;
          if (bit_idx_q == IDX_LAST) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          if (rx_s) begin
            load    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q <= state_d;
      // The counter also restarts between data bits so every bit gets a full period.
      if ((state_d != state_q) || sample_bit) cnt_q <= '0;
      else                                    cnt_q <= cnt_q + CNT_W'(1);
      if (state_q != RX_DATA)  bit_idx_q <= '0;
      else if (sample_bit)     bit_idx_q <= bit_idx_q + 3'd1;
      if (sample_bit) shift_q <= {rx_s, shift_q[7:1]};
    end
  end

  // Handshake: rx_valid is a level held until the consumer pulses rx_ack while it is
  // high; the ack takes effect on the next edge. A new byte arriving on that same edge
  // takes priority and keeps rx_valid high; arriving without an ack it overwrites the
  // unread byte and raises overrun_err for one cycle.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      framing_err <= frame_bad;
      overrun_err <= 1'b0;
      if (load) begin
        rx_data     <= shift_q;
        rx_valid    <= 1'b1;
        overrun_err <= rx_valid && !rx_ack;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: serial frames driven on rx_in, received bytes
// checked through an expected-byte queue against loads seen by a monitor.
module tb_uart_rx_core;
  import uart_pkg::*;

  localparam int BIT_CLKS = 50;
  localparam int LAT      = 477;

  logic       clk;
  logic       reset_b;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       framing_err;
  logic       overrun_err;
  rx_state_e  state_dbg;

  int total;
  int bad;
  int cyc;
  int fall_cyc;
  int fe_cnt;
  int ov_cnt;
  int obs_rd;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc_q[$];

  uart_rx_core #(.CLKS_PER_BIT(BIT_CLKS)) dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .rx_in       (rx_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: a load shows up as rx_valid rising, new data under rx_valid, or an overrun pulse
  initial begin
    logic       prev_valid;
    logic [7:0] prev_data;
    prev_valid = 1'b0;
    prev_data  = 8'h00;
    fe_cnt = 0;
    ov_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset_b === 1'b1) begin
        if ((rx_valid && !prev_valid) || overrun_err || (rx_valid && rx_data !== prev_data)) begin
          obs_q.push_back(rx_data);
          obs_cyc_q.push_back(cyc);
        end
        if (framing_err) fe_cnt = fe_cnt + 1;
        if (overrun_err) ov_cnt = ov_cnt + 1;
      end
      prev_valid = rx_valid;
      prev_data  = rx_data;
    end
  end

  // driver tasks
  task automatic send_frame(input logic [7:0] d, input int stop_len, input logic stop_val);
    rx_in    = 1'b0;
    fall_cyc = cyc + 1;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx_in = stop_val;
    repeat (stop_len) @(negedge clk);
    rx_in = 1'b1;
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_load(output logic ok);
    int n;
    n = 0;
    while (obs_q.size() <= obs_rd && n < 1500) begin
      @(negedge clk);
      n++;
    end
    ok = (obs_q.size() > obs_rd);
  endtask

  // tests
  task automatic test_reset();
    reset_b = 1'b0;
    rx_in   = 1'b1;
    rx_ack  = 1'b0;
    idle(4);
    reset_b = 1'b1;
    idle(2);
    total++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || framing_err !== 1'b0 || overrun_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got data=%h valid=%b fe=%b ov=%b, want 00 0 0 0",
               rx_data, rx_valid, framing_err, overrun_err);
    end
    total++;
    if (state_dbg !== RX_IDLE) begin
      bad++;
      $display("FAIL reset_state: got %0d want %0d", state_dbg, RX_IDLE);
    end
  endtask

  task automatic test_basic();
    int fe0, ov0, lat;
    logic ok;
    logic [7:0] e;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, BIT_CLKS, 1'b1);
    wait_load(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL basic_timeout: no byte received, want a5");
    end else begin
      e = exp_q.pop_front();
      total++;
      if (obs_q[obs_rd] !== e) begin
        bad++;
        $display("FAIL basic_data: got %h want %h", obs_q[obs_rd], e);
      end
      lat = obs_cyc_q[obs_rd] - fall_cyc;
      total++;
      if (lat != LAT) begin
        bad++;
        $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
      end
      obs_rd++;
    end
    total++;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin
      bad++;
      $display("FAIL basic_errs: got fe=%0d ov=%0d want 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    total++;
    if (rx_valid !== 1'b1) begin
      bad++;
      $display("FAIL basic_valid_held: got %b want 1", rx_valid);
    end
    pulse_ack();
    total++;
    if (rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_ack_clear: got %b want 0", rx_valid);
    end
    // an ack with nothing pending is ignored
    pulse_ack();
    total++;
    if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin
      bad++;
      $display("FAIL basic_stray_ack: got valid=%b data=%h want 0 a5", rx_valid, rx_data);
    end
  endtask

  task automatic test_glitch();
    int fe0, n0;
    fe0 = fe_cnt;
    n0  = obs_q.size();
    rx_in = 1'b0;
    idle(10);
    rx_in = 1'b1;
    idle(100);
    total++;
    if (obs_q.size() != n0 || rx_valid !== 1'b0 || fe_cnt != fe0) begin
      bad++;
      $display("FAIL glitch_reject: got loads=%0d valid=%b fe=%0d want 0 0 0",
               obs_q.size() - n0, rx_valid, fe_cnt - fe0);
    end
    total++;
    if (state_dbg !== RX_IDLE) begin
      bad++;
      $display("FAIL glitch_state: got %0d want %0d", state_dbg, RX_IDLE);
    end
  endtask

  task automatic test_framing();
    int fe0, n0;
    logic ok;
    logic [7:0] e;
    fe0 = fe_cnt;
    n0  = obs_q.size();
    send_frame(8'h3C, 200, 1'b0);
    idle(20);
    total++;
    if (fe_cnt - fe0 != 1) begin
      bad++;
      $display("FAIL framing_pulse: got %0d pulses want 1", fe_cnt - fe0);
    end
    total++;
    if (obs_q.size() != n0 || rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL framing_discard: got loads=%0d valid=%b want 0 0", obs_q.size() - n0, rx_valid);
    end
    exp_q.push_back(8'h81);
    send_frame(8'h81, BIT_CLKS, 1'b1);
    wait_load(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL framing_recover_timeout: no byte received, want 81");
    end else begin
      e = exp_q.pop_front();
      total++;
      if (obs_q[obs_rd] !== e) begin
        bad++;
        $display("FAIL framing_recover_data: got %h want %h", obs_q[obs_rd], e);
      end
      obs_rd++;
    end
    pulse_ack();
  endtask

  task automatic test_back_to_back(input logic ack_between);
    int ov0;
    logic ok;
    logic [7:0] e;
    ov0 = ov_cnt;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFF);
    send_frame(8'h01, BIT_CLKS, 1'b1);
    if (ack_between) pulse_ack();
    send_frame(8'hFF, BIT_CLKS, 1'b1);
    for (int k = 0; k < 2; k++) begin
      wait_load(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL b2b_timeout: byte %0d missing (ack_between=%b)", k, ack_between);
        void'(exp_q.pop_front());
      end else begin
        e = exp_q.pop_front();
        total++;
        if (obs_q[obs_rd] !== e) begin
          bad++;
          $display("FAIL b2b_data: byte %0d got %h want %h (ack_between=%b)", k, obs_q[obs_rd], e, ack_between);
        end
        obs_rd++;
      end
    end
    total++;
    if (rx_data !== 8'hFF || rx_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_final: got data=%h valid=%b want ff 1", rx_data, rx_valid);
    end
    total++;
    if (ov_cnt - ov0 != (ack_between ? 0 : 1)) begin
      bad++;
      $display("FAIL b2b_overrun: got %0d pulses want %0d (ack_between=%b)",
               ov_cnt - ov0, ack_between ? 0 : 1, ack_between);
    end
    pulse_ack();
  endtask

  task automatic test_ack_same_cycle();
    int ov0;
    logic ok;
    logic [7:0] e;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, BIT_CLKS, 1'b1);
    ov0 = ov_cnt;
    exp_q.push_back(8'h96);
    fork
      send_frame(8'h96, BIT_CLKS, 1'b1);
      begin
        // lands rx_ack on the very edge that loads the second byte
        repeat (LAT) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
      end
    join
    for (int k = 0; k < 2; k++) begin
      wait_load(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL ack_same_timeout: byte %0d missing", k);
        void'(exp_q.pop_front());
      end else begin
        e = exp_q.pop_front();
        total++;
        if (obs_q[obs_rd] !== e) begin
          bad++;
          $display("FAIL ack_same_data: byte %0d got %h want %h", k, obs_q[obs_rd], e);
        end
        obs_rd++;
      end
    end
    total++;
    if (rx_valid !== 1'b1 || ov_cnt != ov0) begin
      bad++;
      $display("FAIL ack_same_cycle: got valid=%b ov=%0d want 1 0", rx_valid, ov_cnt - ov0);
    end
    pulse_ack();
  endtask

  task automatic test_reset_mid_frame();
    logic ok;
    logic [7:0] e;
    logic [7:0] d;
    d = 8'h55;
    rx_in = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx_in = d[i];
      idle(BIT_CLKS);
    end
    reset_b = 1'b0;
    rx_in   = 1'b1;
    idle(5);
    total++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || framing_err !== 1'b0 ||
        overrun_err !== 1'b0 || state_dbg !== RX_IDLE) begin
      bad++;
      $display("FAIL midframe_reset: got data=%h valid=%b fe=%b ov=%b state=%0d want 00 0 0 0 0",
               rx_data, rx_valid, framing_err, overrun_err, state_dbg);
    end
    reset_b = 1'b1;
    idle(20);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, BIT_CLKS, 1'b1);
    wait_load(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL midframe_recover_timeout: no byte received, want c3");
    end else begin
      e = exp_q.pop_front();
      total++;
      if (obs_q[obs_rd] !== e) begin
        bad++;
        $display("FAIL midframe_recover_data: got %h want %h", obs_q[obs_rd], e);
      end
      obs_rd++;
    end
    pulse_ack();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    obs_rd  = 0;
    fall_cyc = 0;
    reset_b = 1'b0;
    rx_in   = 1'b1;
    rx_ack  = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    idle(30);
    test_glitch();
    test_framing();
    idle(30);
    test_back_to_back(1'b0);
    idle(30);
    test_back_to_back(1'b1);
    idle(30);
    test_ack_same_cycle();
    idle(30);
    test_reset_mid_frame();
    idle(10);
    total++;
    if (obs_q.size() != obs_rd || exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d unmatched loads, %0d unmatched expected",
               obs_q.size() - obs_rd, exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
